// File: rtl/pow_5_pkg.sv
// Shared definitions for the sequential x^5 block: FSM encoding and step counting.
// Optional overflow reporting is enabled by defining POW_5_SEQ_CTRL_OVF_EN.
package pow_5_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      MUL  = 1'b1
   } state_t;

   localparam int N_MUL = 4;
   localparam int CNT_W = 2;

   // Counter value on the last multiply of an operation.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_MUL - 1);

endpackage

// File: rtl/pow_5_mul_dp.sv
// Datapath for x^5: operand, accumulator and result registers around one shared multiplier.
// With POW_5_SEQ_CTRL_OVF_EN defined it also tracks whether any product lost upper bits.
module pow_5_mul_dp
   import pow_5_pkg::*;
#(
   parameter int w = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic         step,
   input  logic         done,
   input  logic [w-1:0] arg,
`ifdef POW_5_SEQ_CTRL_OVF_EN
   output logic         res_ovf,
`endif
   output logic [w-1:0] res
);

   logic [w-1:0] x;
   logic [w-1:0] acc;
   logic [w-1:0] prod;

`ifdef POW_5_SEQ_CTRL_OVF_EN
   logic [2*w-1:0] prod_full;
   logic           prod_hi;
   logic           ovf_acc;

   assign prod_full = {{w{1'b0}}, acc} * {{w{1'b0}}, x};
   assign prod      = prod_full[w-1:0];
   assign prod_hi   = |prod_full[2*w-1:w];

   // Sticky flag over the first three products, folded with the fourth into res_ovf.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_acc <= 1'b0;
         res_ovf <= 1'b0;
      end else if (load) begin
         ovf_acc <= 1'b0;
      end else if (done) begin
         res_ovf <= ovf_acc | prod_hi;
      end else if (step) begin
         ovf_acc <= ovf_acc | prod_hi;
      end
   end
`else
   assign prod = acc * x;
`endif

   // x stays fixed for the whole operation; acc walks through x^2..x^4, res takes x^5.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x   <= '0;
         acc <= '0;
         res <= '0;
      end else if (load) begin
         x   <= arg;
         acc <= arg;
      end else if (done) begin
         res <= prod;
      end else if (step) begin
         acc <= prod;
      end
   end

endmodule

// File: rtl/pow_5_seq_ctrl.sv
// Sequential arg^5 mod 2^w: FSM, step counter and handshake driving pow_5_mul_dp.
// Defining POW_5_SEQ_CTRL_OVF_EN adds the res_ovf output.
module pow_5_seq_ctrl
   import pow_5_pkg::*;
#(
   parameter int w = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         arg_vld,
   output logic         arg_rdy,
   input  logic [w-1:0] arg,
   output logic         res_vld,
   output logic [w-1:0] res,
`ifdef POW_5_SEQ_CTRL_OVF_EN
   output logic         res_ovf,
`endif
   output logic         busy
);

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic             load;
   logic             step;
   logic             done;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (load) state_nxt = MUL;
         MUL:     if (done) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      arg_rdy = (state == IDLE);
      busy    = (state == MUL);
      load    = (state == IDLE) && arg_vld;
      step    = (state == MUL);
      done    = (state == MUL) && (cnt == CNT_LAST);
   end

   // The counter wraps back to zero on the final step, which leaves it ready for the next load.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt     <= '0;
         res_vld <= 1'b0;
      end else begin
         res_vld <= done;
         if (load) begin
            cnt <= '0;
         end else if (step) begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   pow_5_mul_dp #(
      .w(w)
   ) u_dp (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (load),
      .step   (step),
      .done   (done),
      .arg    (arg),
`ifdef POW_5_SEQ_CTRL_OVF_EN
      .res_ovf(res_ovf),
`endif
      .res    (res)
   );

endmodule

// File: tb/tb_pow_5_seq_ctrl.sv
// Bench for pow_5_seq_ctrl at w=8 and w=16 against a cycle-level reference model.
// Overflow checks are compiled in when POW_5_SEQ_CTRL_OVF_EN is defined.
module tb_pow_5_seq_ctrl;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic        arg_vld8  = 1'b0;
   logic        arg_vld16 = 1'b0;
   logic [7:0]  arg8  = '0;
   logic [15:0] arg16 = '0;
   logic        rdy8, vld8, busy8, rdy16, vld16, busy16;
   logic [7:0]  res8;
   logic [15:0] res16;
`ifdef POW_5_SEQ_CTRL_OVF_EN
   logic        ovf8, ovf16;
`endif

   always #5 clk = ~clk;

   pow_5_seq_ctrl #(.w(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .arg_vld(arg_vld8), .arg_rdy(rdy8), .arg(arg8),
      .res_vld(vld8), .res(res8),
`ifdef POW_5_SEQ_CTRL_OVF_EN
      .res_ovf(ovf8),
`endif
      .busy(busy8)
   );

   pow_5_seq_ctrl #(.w(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .arg_vld(arg_vld16), .arg_rdy(rdy16), .arg(arg16),
      .res_vld(vld16), .res(res16),
`ifdef POW_5_SEQ_CTRL_OVF_EN
      .res_ovf(ovf16),
`endif
      .busy(busy16)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: cycles left until the pending result appears, 0 meaning ready.
   int              left     [2] = '{0, 0};
   longint unsigned pend_res [2] = '{0, 0};
   longint unsigned exp_res  [2] = '{0, 0};
   bit              exp_vld  [2] = '{0, 0};
`ifdef POW_5_SEQ_CTRL_OVF_EN
   bit              pend_ovf [2] = '{0, 0};
   bit              exp_ovf  [2] = '{0, 0};
`endif

   function automatic longint unsigned pow5(input longint unsigned a, input int w, output bit ovf);
      longint unsigned m = (64'd1 << w) - 64'd1;
      longint unsigned base = a & m;
      longint unsigned acc = base;
      longint unsigned p;
      ovf = 1'b0;
      for (int i = 0; i < 4; i++) begin
         p = acc * base;
         if ((p >> w) != 0) ovf = 1'b1;
         acc = p & m;
      end
      return acc;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic stepModel(input int ch, input logic v, input longint unsigned a, input int w);
      bit o;
      exp_vld[ch] = 1'b0;
      if (left[ch] > 0) begin
         left[ch]--;
         if (left[ch] == 0) begin
            exp_res[ch] = pend_res[ch];
            exp_vld[ch] = 1'b1;
`ifdef POW_5_SEQ_CTRL_OVF_EN
            exp_ovf[ch] = pend_ovf[ch];
`endif
         end
      end else if (v) begin
         pend_res[ch] = pow5(a, w, o);
         left[ch]     = 4;
`ifdef POW_5_SEQ_CTRL_OVF_EN
         pend_ovf[ch] = o;
`endif
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int ch = 0; ch < 2; ch++) begin
            left[ch]    = 0;
            exp_res[ch] = 0;
            exp_vld[ch] = 1'b0;
`ifdef POW_5_SEQ_CTRL_OVF_EN
            exp_ovf[ch] = 1'b0;
`endif
         end
      end else begin
         stepModel(0, arg_vld8, {56'd0, arg8}, 8);
         stepModel(1, arg_vld16, {48'd0, arg16}, 16);
      end
   end

   always @(negedge clk) begin
      checkOutput("arg_rdy w8", rdy8, left[0] == 0);
      checkOutput("busy w8", busy8, left[0] != 0);
      checkOutput("res_vld w8", vld8, exp_vld[0]);
      checkOutput("res w8", res8, exp_res[0]);
      checkOutput("arg_rdy w16", rdy16, left[1] == 0);
      checkOutput("busy w16", busy16, left[1] != 0);
      checkOutput("res_vld w16", vld16, exp_vld[1]);
      checkOutput("res w16", res16, exp_res[1]);
`ifdef POW_5_SEQ_CTRL_OVF_EN
      checkOutput("res_ovf w8", ovf8, exp_ovf[0]);
      checkOutput("res_ovf w16", ovf16, exp_ovf[1]);
`endif
   end

   task automatic applyStimulus(input int ch, input logic [15:0] a);
      int n = 0;
      @(negedge clk);
      while (!(ch == 0 ? rdy8 : rdy16) && n < 20) begin
         @(negedge clk);
         n++;
      end
      checkOutput("rdy before accept", (ch == 0 ? rdy8 : rdy16), 1);
      if (ch == 0) begin
         arg_vld8 = 1'b1;
         arg8     = a[7:0];
      end else begin
         arg_vld16 = 1'b1;
         arg16     = a;
      end
      @(negedge clk);
      arg_vld8  = 1'b0;
      arg_vld16 = 1'b0;
   endtask

   task automatic waitResult(input int ch, output int lat, output logic [15:0] r);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!(ch == 0 ? vld8 : vld16) && lat < 20);
      r = (ch == 0) ? {8'd0, res8} : res16;
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: time limit reached before end of test");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int          lat;
      logic [15:0] r;
      bit          o;
      int          args [3] = '{4, 0, 1};
      int          exps [3] = '{0, 0, 1};
`ifdef POW_5_SEQ_CTRL_OVF_EN
      int          ovfs [3] = '{1, 0, 0};
`endif

      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;

      @(negedge clk);
      checkOutput("reset res w8", res8, 0);
      checkOutput("reset rdy w8", rdy8, 1);
      checkOutput("reset vld w8", vld8, 0);
      checkOutput("reset busy w8", busy8, 0);
      checkOutput("reset res w16", res16, 0);

      checkOutput("model 3^5 w8", pow5(3, 8, o), 243);
      checkOutput("model ovf 3 w8", o, 0);
      checkOutput("model 4^5 w8", pow5(4, 8, o), 0);
      checkOutput("model ovf 4 w8", o, 1);
      checkOutput("model 10^5 w16", pow5(10, 16, o), 34464);
      checkOutput("model ovf 10 w16", o, 1);

      applyStimulus(0, 16'd3);
      waitResult(0, lat, r);
      checkOutput("latency arg3", lat, 4);
      checkOutput("res arg3", r, 243);
`ifdef POW_5_SEQ_CTRL_OVF_EN
      checkOutput("ovf arg3", ovf8, 0);
`endif
      @(negedge clk);
      checkOutput("res_vld single cycle", vld8, 0);
      checkOutput("res holds", res8, 243);

      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 16'(args[i]));
         waitResult(0, lat, r);
         checkOutput("latency table", lat, 4);
         checkOutput("res table", r, 16'(exps[i]));
`ifdef POW_5_SEQ_CTRL_OVF_EN
         checkOutput("ovf table", ovf8, 1'(ovfs[i]));
`endif
      end

      applyStimulus(1, 16'd10);
      waitResult(1, lat, r);
      checkOutput("latency arg10 w16", lat, 4);
      checkOutput("res arg10 w16", r, 34464);

      // Held-high requester: second accept must land five cycles after the first.
      begin
         int second  = -1;
         int first_v = -1;
         logic [15:0] r1 = '0;
         logic [15:0] r2 = '0;
         @(negedge clk);
         arg_vld8 = 1'b1;
         arg8     = 8'd2;
         for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (i == 1) begin
               checkOutput("rdy low in MUL", rdy8, 0);
               arg8 = 8'd3;
            end
            if (vld8 && first_v < 0) begin
               first_v = i;
               r1 = {8'd0, res8};
            end else if (vld8) begin
               r2 = {8'd0, res8};
            end
            if (second >= 0) arg_vld8 = 1'b0;
            if (rdy8 && second < 0) second = i;
         end
         arg_vld8 = 1'b0;
         checkOutput("b2b accept gap", second, 5);
         checkOutput("b2b rdy with res_vld", first_v, 5);
         checkOutput("b2b res first", r1, 32);
         checkOutput("b2b res second", r2, 243);
      end

      // Stray arg_vld while multiplying must be ignored.
      begin
         int nv = 0;
         applyStimulus(0, 16'd5);
         @(negedge clk);
         arg_vld8 = 1'b1;
         arg8     = 8'd7;
         @(negedge clk);
         arg_vld8 = 1'b0;
         checkOutput("rdy low after stray vld", rdy8, 0);
         r = '0;
         for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (vld8) begin
               nv++;
               r = {8'd0, res8};
            end
         end
         checkOutput("stray vld pulse count", nv, 1);
         checkOutput("stray vld res", r, 53);
      end

      // Reset in the second multiply cycle aborts the operation.
      begin
         int nv = 0;
         applyStimulus(0, 16'd3);
         @(negedge clk);
         #2 rst_n = 1'b0;
         #1;
         checkOutput("abort res cleared", res8, 0);
         checkOutput("abort vld low", vld8, 0);
         checkOutput("abort rdy high", rdy8, 1);
         checkOutput("abort busy low", busy8, 0);
         @(negedge clk);
         #2 rst_n = 1'b1;
         for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (vld8) nv++;
         end
         checkOutput("abort no res_vld", nv, 0);
         checkOutput("abort res stays 0", res8, 0);
         checkOutput("abort rdy after release", rdy8, 1);
         applyStimulus(0, 16'd2);
         waitResult(0, lat, r);
         checkOutput("after abort latency", lat, 4);
         checkOutput("after abort res", r, 32);
      end

      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         arg_vld8  = ($urandom % 3) != 0;
         arg8      = 8'($urandom);
         arg_vld16 = ($urandom % 3) != 0;
         arg16     = 16'($urandom);
      end
      @(negedge clk);
      arg_vld8  = 1'b0;
      arg_vld16 = 1'b0;
      repeat (8) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pow_5_seq_ctrl.md
POW_5_SEQ_CTRL -- requirements
Module: pow_5_seq_ctrl

Interface
REQ-001 Parameter: w, default 8, data width of argument and result.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 arg_vld  input  1  requester offers an argument this cycle.
REQ-005 arg_rdy  output  1  block accepts an argument this cycle.
REQ-006 arg  input  w  argument; sampled only on accept (arg_vld && arg_rdy).
REQ-007 res_vld  output  1  one-cycle pulse: res holds a new result.
REQ-008 res  output  w  arg^5 modulo 2^w.
REQ-009 busy  output  1  high while an operation is in progress (state != IDLE).

Function
REQ-010 Block SHALL compute arg^5 using a single shared w x w multiplier, sequenced over multiple cycles.
REQ-011 FSM states SHALL be IDLE and MUL only.
REQ-012 IDLE: arg_rdy=1; on accept -> load x=arg, acc=arg, step counter=0, go to MUL.
REQ-013 IDLE without accept: SHALL remain in IDLE with all registers unchanged.
REQ-014 MUL: arg_rdy=0; each cycle acc <= low w bits of acc*x, counter increments.
REQ-015 Fourth MUL cycle (counter==3): res <= low w bits of acc*x, res_vld asserted for the next cycle, FSM returns to IDLE.
REQ-016 Latency: accept at edge k -> res/res_vld updated at edge k+4; res_vld high during cycle after k+4 only.
REQ-017 Throughput: one result per 5 cycles; arg_rdy SHALL be high in the same cycle res_vld is high, allowing back-to-back accepts.
REQ-018 res SHALL hold its last value until the next result; res_vld SHALL never be high two consecutive cycles.
REQ-019 arg_vld in MUL SHALL be ignored (no accept, no effect on operation).
REQ-020 Arithmetic: all intermediate products truncated to w bits; x unchanged during MUL.
REQ-021 Step counter SHALL be 2 bits and never wrap during a valid operation.

Reset
REQ-022 On rst_n low: state=IDLE, counter=0, res_vld=0, res=0, acc=0, x=0 immediately (asynchronous).
REQ-023 Reset during MUL SHALL abort the operation; no res_vld is produced for it.
REQ-024 After rst_n deasserts, arg_rdy=1 in the first cycle.

Configuration
REQ-025 Macro POW_5_SEQ_CTRL_OVF_EN: when defined, output res_ovf (1 bit) is present, updated with res at edge k+4, high if any of the four products had nonzero upper w bits; reset value 0.
REQ-026 Without POW_5_SEQ_CTRL_OVF_EN: no res_ovf port, no overflow logic; all other behaviour identical.

Structure
REQ-027 Shared package pow_5_pkg SHALL hold FSM state encoding (IDLE, MUL), step count constant N_MUL=4 and counter width.
REQ-028 One sub-module pow_5_mul_dp SHALL contain x, acc, res registers and the multiplier; pow_5_seq_ctrl holds FSM, counter and handshake, driving load/step/done controls.

Verification
REQ-029 w=8, arg=3 accepted at edge k -> res=243 (0xF3), res_vld pulse after edge k+4, res_ovf=0.
REQ-030 w=8, arg=4 -> res=0 (1024 mod 256), res_ovf=1; arg=0 -> res=0; arg=1 -> res=1, res_ovf=0.
REQ-031 arg_vld held high with arg=2 then 3 -> accepts exactly 5 cycles apart, res=32 then 243, arg_rdy low during MUL.
REQ-032 arg_vld pulsed with arg=7 during MUL -> ignored; in-flight result unchanged, no extra res_vld.
REQ-033 rst_n low at second MUL cycle -> res_vld never asserts, res=0, arg_rdy=1 after release; next arg=2 -> res=32.
REQ-034 Random args, w=8 and w=16 -> res equals arg^5 mod 2^w, latency 4 edges from accept, res_vld single-cycle.
